// File: rtl/m_ext_pkg.sv
// -----------------------------------------------------------------------------
// m_ext_pkg
// Definitions shared by the M-extension divide path.
//   XLEN                 : architectural register width, default operand width
//   type_div_states_e    : divider FSM states (IDLE / CALC / DONE)
//   DIV_BY_ZERO_QUO_BIT  : fill bit of the divide-by-zero quotient; the
//                          quotient of x/0 is this bit replicated (all ones)
// -----------------------------------------------------------------------------
package m_ext_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } type_div_states_e;

    localparam logic DIV_BY_ZERO_QUO_BIT = 1'b1;

endpackage : m_ext_pkg

// File: rtl/div_lzc.sv
// -----------------------------------------------------------------------------
// div_lzc
// Parameterized leading-zero counter used by the divider's early-termination
// preload. Only compiled when DIV_EARLY_TERM_EN is defined, so the default
// build carries no leading-zero logic at all.
//
// Parameters:
//   W   : input width
//   CW  : count width, wide enough to hold W (all-zero input)
// Ports:
//   value  in  W   word to scan from the MSB down
//   zeros  out CW  number of leading zero bits (W when value is zero)
// -----------------------------------------------------------------------------
`ifdef DIV_EARLY_TERM_EN
module div_lzc #(
    parameter int W  = 32,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] zeros
);

    logic found_s;

    // Priority scan from the MSB: first set bit fixes the count.
    always_comb begin
        zeros   = CW'(W);
        found_s = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found_s && value[i]) begin
                zeros   = CW'(W - 1 - i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule : div_lzc
`endif

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative radix-2 restoring unsigned divider, one quotient bit per cycle.
// Signs are handled by the surrounding M-extension unit; this block only
// produces the unsigned quotient and remainder.
//
// Configuration macro: DIV_EARLY_TERM_EN
//   Defined   : dividend leading zeros are skipped at start (shorter CALC),
//               zero dividend with nonzero divisor finishes immediately.
//   Undefined : every nonzero divisor takes exactly DATA_W CALC cycles.
//   Results are identical in both builds; only latency differs.
//
// Parameters:
//   DATA_W   operand/result width (default XLEN)
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   start_i  in   request, sampled only in IDLE
//   abort_i  in   pipeline flush, cancels any in-flight division
//   opr1_i   in   dividend (unsigned), captured on accepted start
//   opr2_i   in   divisor  (unsigned), captured on accepted start
//   busy_o   out  high while in CALC or DONE
//   done_o   out  single-cycle completion pulse
//   quo_o    out  quotient, held until overwritten by the next completion
//   rem_o    out  remainder, same validity as quo_o
// -----------------------------------------------------------------------------
module seq_divider
    import m_ext_pkg::*;
#(
    parameter int DATA_W = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] opr1_i,
    input  logic [DATA_W-1:0] opr2_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] quo_o,
    output logic [DATA_W-1:0] rem_o
);

    localparam int                CNT_W   = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] ZERO_W  = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] DBZ_QUO = {DATA_W{DIV_BY_ZERO_QUO_BIT}};
    localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(DATA_W - 1);

    // Registered state
    type_div_states_e  state_r;
    logic [DATA_W-1:0] r_r;      // partial remainder
    logic [DATA_W-1:0] q_r;      // dividend shift-in / quotient shift-out
    logic [DATA_W-1:0] d_r;      // divisor
    logic [CNT_W-1:0]  cnt_r;    // remaining iterations minus one
    logic [DATA_W-1:0] quo_r;
    logic [DATA_W-1:0] rem_r;
    logic              done_r;
    logic              busy_r;

    // Next-state values
    type_div_states_e  state_s;
    logic [DATA_W-1:0] r_s;
    logic [DATA_W-1:0] q_s;
    logic [DATA_W-1:0] d_s;
    logic [CNT_W-1:0]  cnt_s;
    logic [DATA_W-1:0] quo_s;
    logic [DATA_W-1:0] rem_s;
    logic              done_s;
    logic              busy_s;

    // Trial subtraction, one bit wider so its MSB is the borrow (negative)
    logic [DATA_W:0]   trial_s;

`ifdef DIV_EARLY_TERM_EN
    localparam int LZ_W = $clog2(DATA_W + 1);
    logic [LZ_W-1:0] lz_s;

    div_lzc #(
        .W  (DATA_W),
        .CW (LZ_W)
    ) u_lzc (
        .value (opr1_i),
        .zeros (lz_s)
    );
`endif

    // Next-state, datapath and output-load logic for the divider FSM.
    always_comb begin
        state_s = state_r;
        r_s     = r_r;
        q_s     = q_r;
        d_s     = d_r;
        cnt_s   = cnt_r;
        quo_s   = quo_r;
        rem_s   = rem_r;
        done_s  = 1'b0;

        trial_s = {r_r, q_r[DATA_W-1]} - {1'b0, d_r};

        if (abort_i) begin
            // Flush wins over start and over a completing iteration;
            // published results are left untouched.
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        d_s = opr2_i;
                        if (opr2_i == ZERO_W) begin
                            state_s = DONE;
                            quo_s   = DBZ_QUO;
                            rem_s   = opr1_i;
                            done_s  = 1'b1;
`ifdef DIV_EARLY_TERM_EN
                        end else if (opr1_i == ZERO_W) begin
                            state_s = DONE;
                            quo_s   = ZERO_W;
                            rem_s   = ZERO_W;
                            done_s  = 1'b1;
                        end else begin
                            // Leading zeros of the dividend would only shift
                            // zero quotient bits in, so skip them.
                            state_s = CALC;
                            r_s     = ZERO_W;
                            q_s     = opr1_i << lz_s;
                            cnt_s   = CNT_TOP - CNT_W'(lz_s);
                        end
`else
                        end else begin
                            state_s = CALC;
                            r_s     = ZERO_W;
                            q_s     = opr1_i;
                            cnt_s   = CNT_TOP;
                        end
`endif
                    end else begin
                        state_s = IDLE;
                    end
                end

                CALC: begin
                    if (trial_s[DATA_W]) begin
                        // Borrow: restore, shift the dividend bit into R.
                        r_s = {r_r[DATA_W-2:0], q_r[DATA_W-1]};
                        q_s = {q_r[DATA_W-2:0], 1'b0};
                    end else begin
                        r_s = trial_s[DATA_W-1:0];
                        q_s = {q_r[DATA_W-2:0], 1'b1};
                    end

                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_s = DONE;
                        quo_s   = q_s;
                        rem_s   = r_s;
                        done_s  = 1'b1;
                    end else begin
                        cnt_s   = cnt_r - CNT_W'(1);
                    end
                end

                DONE: begin
                    state_s = IDLE;
                end

                default: begin
                    state_s = IDLE;
                end
            endcase
        end

        busy_s = (state_s != IDLE);
    end

    // State, datapath and registered output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            r_r     <= ZERO_W;
            q_r     <= ZERO_W;
            d_r     <= ZERO_W;
            cnt_r   <= {CNT_W{1'b0}};
            quo_r   <= ZERO_W;
            rem_r   <= ZERO_W;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            r_r     <= r_s;
            q_r     <= q_s;
            d_r     <= d_s;
            cnt_r   <= cnt_s;
            quo_r   <= quo_s;
            rem_r   <= rem_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
        end
    end

    assign busy_o = busy_r;
    assign done_o = done_r;
    assign quo_o  = quo_r;
    assign rem_o  = rem_r;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (DATA_W = 32). Expected quotient,
// remainder and latency come from constant tables and a plain-arithmetic
// reference model. Latency expectations follow DIV_EARLY_TERM_EN.
// -----------------------------------------------------------------------------
module tb_seq_divider;

`ifdef DIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        abort_i;
    logic [31:0] opr1_i;
    logic [31:0] opr2_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] quo_o;
    logic [31:0] rem_o;

    int checks;
    int errors;

    seq_divider #(.DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .abort_i (abort_i),
        .opr1_i  (opr1_i),
        .opr2_i  (opr2_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .quo_o   (quo_o),
        .rem_o   (rem_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat_fixed;
        int          lat_early;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle of done_o counted from the start-sampling edge.
    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
        int          bits;
        logic [31:0] x;
        bits = 0;
        x    = a;
        while (x != 32'd0) begin
            x = x >> 1;
            bits++;
        end
        if (b == 32'd0) return 1;
        if (EARLY) begin
            if (a == 32'd0) return 1;
            return bits + 1;
        end else begin
            return 33;
        end
    endfunction

    // Issue one start pulse and wait (bounded) for done_o.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r,
                          output int lat, output logic busy_ok);
        @(negedge clk);
        start_i = 1'b1;
        opr1_i  = a;
        opr2_i  = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            busy_ok = busy_ok & busy_o;
            if (done_o) begin
                lat = k;
                break;
            end
        end
        q = quo_o;
        r = rem_o;
    endtask

    // Run one op and compare against given expectations.
    task automatic verify_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eq, input logic [31:0] er, input int elat);
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        logic        bok;
        run_op(a, b, q, r, lat, bok);
        check({tag, " quo"}, 64'(q), 64'(eq));
        check({tag, " rem"}, 64'(r), 64'(er));
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " busy during op"}, 64'(bok), 64'd1);
        @(negedge clk);
        check({tag, " done single pulse"}, 64'(done_o), 64'd0);
        check({tag, " busy after done"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        int          mode;
        int          seen;

        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        opr1_i  = 32'd0;
        opr2_i  = 32'd0;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,     33, 8};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,     33, 33};
        vecs[2] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,     1,  1};
        vecs[3] = '{32'd3,          32'd10,         32'd0,          32'd3,     33, 3};
        vecs[4] = '{32'd0,          32'd9,          32'd0,          32'd0,     33, 1};
        vecs[5] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,     33, 33};
        vecs[6] = '{32'd7,          32'd7,          32'd1,          32'd0,     33, 4};
        vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,     33, 33};
        vecs[8] = '{32'd12345,      32'h0001_0000,  32'd0,          32'd12345, 33, 15};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset done", 64'(done_o), 64'd0);
        check("reset quo", 64'(quo_o), 64'd0);
        check("reset rem", 64'(rem_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", 64'(busy_o), 64'd0);

        // Directed table
        foreach (vecs[i]) begin
            verify_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                      EARLY ? vecs[i].lat_early : vecs[i].lat_fixed);
        end

        // Start held high through DONE: one done, next op only from IDLE
        @(negedge clk);
        start_i = 1'b1;
        opr1_i  = 32'd100;
        opr2_i  = 32'd7;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done_o) begin
                lat = k;
                break;
            end
        end
        check("hold latency", 64'(lat), 64'(exp_lat(32'd100, 32'd7)));
        check("hold quo", 64'(quo_o), 64'd14);
        @(negedge clk);
        check("hold done not repeated", 64'(done_o), 64'd0);
        check("hold idle after done", 64'(busy_o), 64'd0);
        @(negedge clk);
        check("hold restart accepted", 64'(busy_o), 64'd1);
        check("hold restart no done", 64'(done_o), 64'd0);
        start_i = 1'b0;
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1;
                break;
            end
        end
        check("hold second op done", 64'(seen), 64'd1);
        check("hold second quo", 64'(quo_o), 64'd14);
        check("hold second rem", 64'(rem_o), 64'd2);
        @(negedge clk);

        // Abort in CALC cycle 10
        @(negedge clk);
        start_i = 1'b1;
        opr1_i  = 32'd1000;
        opr2_i  = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        check("abort busy in calc", 64'(busy_o), 64'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort busy low", 64'(busy_o), 64'd0);
        check("abort no done", 64'(done_o), 64'd0);
        check("abort quo kept", 64'(quo_o), 64'd14);
        check("abort rem kept", 64'(rem_o), 64'd2);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o) seen = 1;
        end
        check("abort no late done", 64'(seen), 64'd0);

        // Abort together with start in IDLE: request is dropped
        start_i = 1'b1;
        abort_i = 1'b1;
        opr1_i  = 32'd5;
        opr2_i  = 32'd0;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        check("abort+start busy", 64'(busy_o), 64'd0);
        check("abort+start done", 64'(done_o), 64'd0);
        check("abort+start quo kept", 64'(quo_o), 64'd14);

        // Reset mid-CALC
        run_op(32'd100, 32'd7, q, r, lat, mode[0]);
        @(negedge clk);
        start_i = 1'b1;
        opr1_i  = 32'hDEAD_BEEF;
        opr2_i  = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", 64'(busy_o), 64'd0);
        check("midrst done", 64'(done_o), 64'd0);
        check("midrst quo", 64'(quo_o), 64'd0);
        check("midrst rem", 64'(rem_o), 64'd0);

        // Random pairs against the arithmetic model
        for (int n = 0; n < 1000; n++) begin
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 3);
            case (mode)
                1: b = $urandom_range(0, 15);
                2: a = a >> $urandom_range(0, 31);
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            if (b == 32'd0) begin
                q = 32'hFFFF_FFFF;
                r = a;
            end else begin
                q = a / b;
                r = a % b;
            end
            verify_op($sformatf("rnd%0d %0h/%0h", n, a, b), a, b, q, r, exp_lat(a, b));
            if (b != 32'd0) begin
                check("rnd identity", 64'(quo_o) * 64'(b) + 64'(rem_o), 64'(a));
                check("rnd rem<div", 64'(rem_o < b), 64'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_divider
